// File: rtl/sa_drain_if.sv
// Aligned output-vector handshake between sa_drain and its downstream consumer.
// The master drives the FIFO head vector and valid; the slave returns ready.
interface sa_drain_if #(
   parameter int ADD_DATAWIDTH = 32,
   parameter int NUM_COLS      = 4
);
   logic [NUM_COLS-1:0][ADD_DATAWIDTH-1:0] vec_data;
   logic                                   vec_valid;
   logic                                   vec_ready;

   modport master (
      output vec_data,
      output vec_valid,
      input  vec_ready
   );

   modport slave (
      input  vec_data,
      input  vec_valid,
      output vec_ready
   );
endinterface

// File: rtl/sa_drain.sv
// sa_drain: de-skews staggered systolic column psums into aligned vectors, FIFO-buffered.
// Optional SA_DRAIN_RELU_EN clamps negative elements to zero at the FIFO write port.
module sa_drain #(
   parameter int ADD_DATAWIDTH = 32,
   parameter int NUM_COLS      = 4,
   parameter int PIPE_LAT      = 4,
   parameter int FIFO_DEPTH    = 8,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   i_start,
   input  logic [CNT_WIDTH-1:0]                   i_num_vec,
   input  logic [NUM_COLS-1:0][ADD_DATAWIDTH-1:0] i_psum,
   sa_drain_if.master                             vec,
   output logic                                   o_busy,
   output logic                                   o_done,
   output logic                                   o_overflow
);

   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int WAIT_N = PIPE_LAT + NUM_COLS - 2;
   localparam int WW     = $clog2(PIPE_LAT + NUM_COLS) + 1;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_WAIT    = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_FLUSH   = 2'd3;

   typedef logic [NUM_COLS-1:0][ADD_DATAWIDTH-1:0] vec_t;

   logic [1:0]               state;
   logic [WW-1:0]            wait_cnt;
   logic [CNT_WIDTH-1:0]     rem;
   logic                     zero_pend;
   logic [ADD_DATAWIDTH-1:0] aligned [NUM_COLS];
   vec_t                     wdata;
   vec_t                     mem [FIFO_DEPTH];
   logic [AW:0]              wr_ptr;
   logic [AW:0]              rd_ptr;
   logic                     empty;
   logic                     full;
   logic                     push;
   logic                     pop;
   logic                     wr_en;

   // Column c is delayed NUM_COLS-1-c cycles so all columns line up.
   genvar gc;
   generate
      for (gc = 0; gc < NUM_COLS; gc++) begin : g_col
         if (gc == NUM_COLS - 1) begin : g_tap
            assign aligned[gc] = i_psum[gc];
         end else begin : g_dly
            localparam int D = NUM_COLS - 1 - gc;
            logic [ADD_DATAWIDTH-1:0] sr [D];
            always_ff @(posedge clk) begin
               if (rst) begin
                  for (int j = 0; j < D; j++) sr[j] <= '0;
               end else begin
                  sr[0] <= i_psum[gc];
                  for (int j = 1; j < D; j++) sr[j] <= sr[j-1];
               end
            end
            assign aligned[gc] = sr[D-1];
         end
      end
   endgenerate

   always_comb begin
      wdata = '0;
      for (int c = 0; c < NUM_COLS; c++) begin
`ifdef SA_DRAIN_RELU_EN
         wdata[c] = aligned[c][ADD_DATAWIDTH-1] ? '0 : aligned[c];
`else
         wdata[c] = aligned[c];
`endif
      end
   end

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW])
               && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push  = (state == S_CAPTURE);
   assign pop   = !empty && vec.vec_ready;
   // A full FIFO still takes the push when the head leaves on the same edge.
   assign wr_en = push && (!full || pop);

   assign vec.vec_valid = !empty;
   assign vec.vec_data  = mem[rd_ptr[AW-1:0]];
   assign o_busy        = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         wait_cnt   <= '0;
         rem        <= '0;
         zero_pend  <= 1'b0;
         o_done     <= 1'b0;
         o_overflow <= 1'b0;
      end else begin
         o_done    <= zero_pend;
         zero_pend <= 1'b0;
         if (push && full && !pop) o_overflow <= 1'b1;
         unique case (state)
            S_IDLE: begin
               if (i_start) begin
                  if (i_num_vec == '0) begin
                     zero_pend <= 1'b1;
                  end else begin
                     rem      <= i_num_vec;
                     wait_cnt <= WW'(WAIT_N);
                     state    <= (WAIT_N == 0) ? S_CAPTURE : S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (wait_cnt == WW'(1)) state <= S_CAPTURE;
               else wait_cnt <= wait_cnt - 1'b1;
            end
            S_CAPTURE: begin
               rem <= rem - 1'b1;
               if (rem == CNT_WIDTH'(1)) state <= S_FLUSH;
            end
            S_FLUSH: begin
               if (empty) begin
                  state  <= S_IDLE;
                  o_done <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sa_drain.sv
// Directed table-driven bench for sa_drain (NUM_COLS=4, PIPE_LAT=4, FIFO_DEPTH=4).
// Cycle n is the interval after edge n, edge 0 samples i_start.
module tb_sa_drain;

   typedef logic [3:0][31:0] vec_t;

   typedef struct {
      int n;
      int rdy_from;
      int rdy_pulse;
      int start2;
      int rst_cyc;
   } scen_t;

   typedef struct {
      int   s;
      int   c;
      logic v;
      logic b;
      logic d;
      logic o;
      int   k;
   } chk_t;

   logic        clk;
   logic        rst;
   logic        i_start;
   logic [15:0] i_num_vec;
   vec_t        i_psum;
   logic        o_busy;
   logic        o_done;
   logic        o_overflow;

   int n_chk;
   int n_fail;

   scen_t sc [8];
   chk_t  chk [$];

   sa_drain_if #(.ADD_DATAWIDTH(32), .NUM_COLS(4)) vif ();

   sa_drain #(
      .ADD_DATAWIDTH(32),
      .NUM_COLS(4),
      .PIPE_LAT(4),
      .FIFO_DEPTH(4),
      .CNT_WIDTH(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .i_start(i_start),
      .i_num_vec(i_num_vec),
      .i_psum(i_psum),
      .vec(vif.master),
      .o_busy(o_busy),
      .o_done(o_done),
      .o_overflow(o_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] psum_val(int s, int k, int c, int n);
      if (k < 0 || k >= n) return 32'h5A5A_0000 | 32'(c);
      if (s == 7 && k == 0 && c == 0) return 32'hFFFF_FFF6;
      return 32'(100 * k + c);
   endfunction

   function automatic vec_t exp_vec(int s, int k);
      vec_t r;
      for (int c = 0; c < 4; c++) begin
         r[c] = psum_val(s, k, c, 1000);
`ifdef SA_DRAIN_RELU_EN
         if (r[c][31]) r[c] = 32'h0;
`endif
      end
      return r;
   endfunction

   function automatic logic rdy(int s, int n);
      return (n >= sc[s].rdy_from) || (n == sc[s].rdy_pulse);
   endfunction

   // Drive the psums that edge e will sample.
   task automatic drive_psum(int s, int e);
      for (int c = 0; c < 4; c++) i_psum[c] = psum_val(s, e - 4 - c, c, sc[s].n);
   endtask

   task automatic cmp(string nm, logic [127:0] act, logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add(int s, int c, logic v, logic b, logic d, logic o, int k);
      chk_t r;
      r.s = s; r.c = c; r.v = v; r.b = b; r.d = d; r.o = o; r.k = k;
      chk.push_back(r);
   endtask

   task automatic do_check(chk_t r);
      string p;
      p = $sformatf("s%0d c%0d", r.s, r.c);
      cmp({p, " valid"}, 128'(vif.vec_valid), 128'(r.v));
      cmp({p, " busy"}, 128'(o_busy), 128'(r.b));
      cmp({p, " done"}, 128'(o_done), 128'(r.d));
      cmp({p, " overflow"}, 128'(o_overflow), 128'(r.o));
      if (r.k >= 0) cmp({p, " data"}, 128'(vif.vec_data), 128'(exp_vec(r.s, r.k)));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      i_start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      rst = 1'b1;
      i_start = 1'b0;
      i_num_vec = '0;
      i_psum = '0;
      vif.vec_ready = 1'b0;

      sc[0] = '{3, -1, -9, -9, -9};
      sc[1] = '{4, 15, -9, -9, -9};
      sc[2] = '{5, 14, -9, -9, -9};
      sc[3] = '{5, 13, 10, -9, -9};
      sc[4] = '{0, -1, -9, -9, -9};
      sc[5] = '{3, -1, -9, 4, -9};
      sc[6] = '{3, -1, -9, -9, 7};
      sc[7] = '{1, -1, -9, -9, -9};

      add(0, 0, 0, 1, 0, 0, -1); add(0, 6, 0, 1, 0, 0, -1);
      add(0, 7, 1, 1, 0, 0, 0);  add(0, 8, 1, 1, 0, 0, 1);
      add(0, 9, 1, 1, 0, 0, 2);  add(0, 10, 0, 1, 0, 0, -1);
      add(0, 11, 0, 0, 1, 0, -1); add(0, 12, 0, 0, 0, 0, -1);
      add(1, 7, 1, 1, 0, 0, 0);  add(1, 12, 1, 1, 0, 0, 0);
      add(1, 15, 1, 1, 0, 0, 0); add(1, 16, 1, 1, 0, 0, 1);
      add(1, 17, 1, 1, 0, 0, 2); add(1, 18, 1, 1, 0, 0, 3);
      add(1, 19, 0, 1, 0, 0, -1); add(1, 20, 0, 0, 1, 0, -1);
      add(2, 10, 1, 1, 0, 0, 0); add(2, 11, 1, 1, 0, 1, 0);
      add(2, 13, 1, 1, 0, 1, 0); add(2, 15, 1, 1, 0, 1, 1);
      add(2, 16, 1, 1, 0, 1, 2); add(2, 17, 1, 1, 0, 1, 3);
      add(2, 18, 0, 1, 0, 1, -1); add(2, 19, 0, 0, 1, 1, -1);
      add(2, 21, 0, 0, 0, 1, -1);
      add(3, 10, 1, 1, 0, 0, 0); add(3, 11, 1, 1, 0, 0, 1);
      add(3, 12, 1, 1, 0, 0, 1); add(3, 14, 1, 1, 0, 0, 2);
      add(3, 15, 1, 1, 0, 0, 3); add(3, 16, 1, 1, 0, 0, 4);
      add(3, 17, 0, 1, 0, 0, -1); add(3, 18, 0, 0, 1, 0, -1);
      add(4, 0, 0, 0, 0, 0, -1); add(4, 1, 0, 0, 1, 0, -1);
      add(4, 2, 0, 0, 0, 0, -1);
      add(5, 7, 1, 1, 0, 0, 0);  add(5, 9, 1, 1, 0, 0, 2);
      add(5, 10, 0, 1, 0, 0, -1); add(5, 11, 0, 0, 1, 0, -1);
      add(5, 13, 0, 0, 0, 0, -1);
      add(6, 7, 1, 1, 0, 0, 0);  add(6, 8, 0, 0, 0, 0, -1);
      add(6, 9, 0, 0, 0, 0, -1); add(6, 11, 0, 0, 0, 0, -1);
      add(6, 12, 0, 0, 0, 0, -1);
      add(7, 7, 1, 1, 0, 0, 0);  add(7, 8, 0, 1, 0, 0, -1);
      add(7, 9, 0, 0, 1, 0, -1);

      do_reset();
      cmp("reset valid", 128'(vif.vec_valid), 128'(0));
      cmp("reset busy", 128'(o_busy), 128'(0));
      cmp("reset done", 128'(o_done), 128'(0));
      cmp("reset overflow", 128'(o_overflow), 128'(0));
      cmp("reset data", 128'(vif.vec_data), 128'(0));

      for (int s = 0; s < 8; s++) begin
         do_reset();
         vif.vec_ready = rdy(s, -1);
         i_start = 1'b1;
         i_num_vec = 16'(sc[s].n);
         drive_psum(s, 0);
         for (int n = 0; n <= 22; n++) begin
            @(posedge clk);
            #1;
            foreach (chk[i]) if (chk[i].s == s && chk[i].c == n) do_check(chk[i]);
            i_start = (n == sc[s].start2);
            i_num_vec = (n == sc[s].start2) ? 16'd7 : 16'(sc[s].n);
            rst = (n == sc[s].rst_cyc);
            vif.vec_ready = rdy(s, n);
            drive_psum(s, n + 1);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sa_drain.md
Name: sa_drain

Overview:
- Output-side drain/de-skew unit for the weight-stationary systolic compute array.
- Samples the array's column partial sums, which arrive staggered one cycle per column.
- Re-aligns each column's values into one full-width output vector per activation vector, buffers the vectors in a FIFO, and hands them downstream over a valid/ready handshake.
- Sits between the compute array's o_psum and the output buffer / accumulator writer.

Parameters:
- ADD_DATAWIDTH, 32: width of each psum element.
- NUM_COLS, 4: array columns, i.e. elements per output vector.
- PIPE_LAT, 4: cycles from the i_start edge to the first column-0 psum at i_psum (set to the array's NUM_ROWS).
- FIFO_DEPTH, 8: output vector FIFO entries, power of two, ≥2.
- CNT_WIDTH, 16: width of the vector count.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  pulse that begins a drain; sampled only in IDLE.
- i_num_vec  in  CNT_WIDTH  number of vectors N to capture; sampled with i_start.
- i_psum  in  ADD_DATAWIDTH x [NUM_COLS]  array bottom-row psums (skewed).
- o_vec_data  out  ADD_DATAWIDTH x [NUM_COLS]  aligned vector at the FIFO head.
- o_vec_valid  out  1  FIFO non-empty.
- i_vec_ready  in  1  downstream accepts o_vec_data.
- o_busy  out  1  FSM not in IDLE.
- o_done  out  1  one-cycle pulse when a drain completes.
- o_overflow  out  1  sticky; a vector was dropped because the FIFO was full.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, FIFO emptied, deskew registers 0, o_overflow cleared.
- Timing origin: edge E0 is the edge that samples i_start.
  - Column c of vector k is valid at i_psum[c] on edge E0+PIPE_LAT+k+c.
  - Column c passes through NUM_COLS-1-c deskew registers (column NUM_COLS-1 has none).
  - The aligned vector k is pushed on edge E0+PIPE_LAT+NUM_COLS-1+k.
- FSM states:
  - IDLE: on i_start with N>0, latch N and go to WAIT. On i_start with N==0, stay in IDLE and pulse o_done in the next cycle.
  - WAIT: count PIPE_LAT+NUM_COLS-1 edges, then go to CAPTURE.
  - CAPTURE: push one aligned vector per edge, N pushes total, then go to FLUSH.
  - FLUSH: when FIFO empty, go to IDLE and assert o_done for exactly that cycle.
- i_start outside IDLE is ignored; it causes no state change.
- The array cannot be stalled, so a push never waits.
  - Push while full with no pop in the same edge: vector dropped, o_overflow set, FIFO contents unchanged.
  - Push while full with a pop in the same edge: push accepted, no overflow.
- FIFO:
  - Registered, no fall-through: a pushed vector appears on o_vec_data in the cycle after the push edge.
  - Pop occurs on an edge with o_vec_valid && i_vec_ready.
  - o_vec_data is held stable while o_vec_valid && !i_vec_ready.
  - Strict in-order delivery; pointers wrap modulo FIFO_DEPTH.
- o_vec_data is don't-care when o_vec_valid=0, but is driven to 0 after reset.
- Data is passed through unmodified: no arithmetic, width preserved.
- rst mid-operation: aborts immediately, returns to IDLE, discards FIFO contents; no o_done pulse.
- o_overflow clears only on rst.

Optional Feature:
- Macro: SA_DRAIN_RELU_EN.
- Defined: each element is treated as signed and clamped to 0 if negative, at the FIFO write port. No added latency.
- Undefined: elements pass through unchanged.

Test Plan:
All scenarios use NUM_COLS=4, PIPE_LAT=4, FIFO_DEPTH=4. Cycle n is the interval after edge n, with E0=0.
1. Basic drain: N=3, i_vec_ready=1, i_psum[c]=100*k+c driven at edge 4+k+c -> o_vec_valid high in cycles 7,8,9 with vectors {0,1,2,3}, {100,101,102,103}, {200,201,202,203}; o_done high only in cycle 11; o_busy low from cycle 11.
2. Backpressure: N=4, i_vec_ready=0 until cycle 15, then 1 -> FIFO holds 4 vectors, o_vec_data stays {0,1,2,3} through cycle 15, all four delivered in order, o_overflow=0.
3. Overflow: N=5, i_vec_ready=0 throughout -> 5th push at edge 11 is dropped, o_overflow=1 from cycle 11 and stays high after the FIFO drains; FIFO holds vectors 0-3.
4. Full plus pop at the same edge: same as scenario 3 but i_vec_ready=1 only at edge 11 -> o_overflow stays 0, vectors 1-4 remain, all 5 delivered.
5. Control corners:
   - N=0 -> o_done in cycle 1, o_busy stays 0.
   - i_start at edge 5 during a busy drain -> ignored.
   - rst at edge 8 of a N=3 drain -> cycle 8 shows o_vec_valid=0, o_busy=0, no o_done.
6. ReLU: i_psum element 0xFFFFFFF6 -> 0x00000000 with SA_DRAIN_RELU_EN defined; 0xFFFFFFF6 unchanged without it.
